// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types and constants for the bin2bcd sharing arbiter.
// Holds the FSM state encoding and the id-width helper used to size grant indices.
package bcd_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_W       = 8;
    localparam int DEF_BCD_W   = 16;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_e;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Client-side and converter-side signals of the shared bin2bcd arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface bcd_conv_arbiter_if #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int BCD_W = 16
);
    logic [N-1:0]         req;
    logic [N-1:0][W-1:0]  bin_in;
    logic [N-1:0]         done;
    logic [N-1:0]         err;
    logic [BCD_W-1:0]     bcd_out;
    logic                 busy;
    logic                 conv_start;
    logic [W-1:0]         conv_bin;
    logic [BCD_W-1:0]     conv_bcd;
    logic                 conv_done_tick;
    logic                 conv_ready;

    modport slave (
        input  req, bin_in, conv_bcd, conv_done_tick, conv_ready,
        output done, err, bcd_out, busy, conv_start, conv_bin
    );

    modport master (
        output req, bin_in, conv_bcd, conv_done_tick, conv_ready,
        input  done, err, bcd_out, busy, conv_start, conv_bin
    );
endinterface

// File: rtl/bcd_conv_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Kept generic so other shared-resource controllers can reuse it.
module rr_arbiter
    import bcd_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one bin2bcd among N requesters: round-robin grant, start/done_tick
// sequencing, per-owner done/err pulses and a watchdog on hung conversions.
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int BCD_W   = DEF_BCD_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    bcd_conv_arbiter_if.slave bus
);

    localparam int IW  = id_w(N);
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] TO_LAST = WDW'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gid_q, gid_d;
    logic [W-1:0]       bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [WDW-1:0]     wdog_q, wdog_d;
    logic [N-1:0]       done_q, done_d;
    logic [N-1:0]       err_q, err_d;
    logic               start;

    logic [N-1:0]       arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic [IW-1:0]      gid_nxt;

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign gid_nxt = (gid_q == IW'(N - 1)) ? '0 : gid_q + IW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            wdog_q  <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            wdog_q  <= wdog_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        wdog_d  = wdog_q;
        done_d  = '0;
        err_d   = '0;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Operand is latched here only; later bin_in changes cannot reach the converter.
                if (arb_any) begin
                    gid_d   = arb_idx;
                    bin_d   = bus.bin_in[arb_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.conv_ready) begin
                    start   = 1'b1;
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // done_tick is checked first so it wins over a same-cycle timeout.
                if (bus.conv_done_tick) begin
                    bcd_d   = bus.conv_bcd;
                    state_d = S_DELIVER;
                end else if (wdog_q == TO_LAST) begin
                    err_d[gid_q] = 1'b1;
                    ptr_d        = gid_nxt;
                    state_d      = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            S_DELIVER: begin
                done_d[gid_q] = 1'b1;
                ptr_d         = gid_nxt;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.bcd_out    = bcd_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.conv_start = start;
    assign bus.conv_bin   = bin_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: behavioural bin2bcd with fixed latency, directed
// vectors pushing expected results into a scoreboard drained by a monitor.
module tb_bcd_conv_arbiter;

    localparam int N = 4, W = 8, BCD_W = 16, TIMEOUT = 64, LAT = 10;

    typedef struct {
        int               id;
        bit               is_err;
        logic [BCD_W-1:0] bcd;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    // converter model state
    bit               ready_en = 1'b1;
    bit               stub     = 1'b0;
    bit               cv_busy;
    bit               cv_done;
    int               cv_cnt;
    logic [W-1:0]     cv_bin;
    logic [BCD_W-1:0] cv_bcd;
    int               start_cnt;
    int               st_cyc;

    bcd_conv_arbiter_if #(.N(N), .W(W), .BCD_W(BCD_W)) bus ();

    bcd_conv_arbiter #(.N(N), .W(W), .BCD_W(BCD_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [BCD_W-1:0] to_bcd(input logic [W-1:0] b);
        return {4'd0, 4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
    endfunction

    assign bus.conv_ready     = ready_en && !cv_busy;
    assign bus.conv_done_tick = cv_done;
    assign bus.conv_bcd       = cv_bcd;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cv_busy <= 1'b0;
            cv_done <= 1'b0;
            cv_cnt  <= 0;
            cv_bin  <= '0;
            cv_bcd  <= '0;
        end else begin
            cv_done <= 1'b0;
            if (cv_busy) begin
                if (cv_cnt == 1) begin
                    cv_busy <= 1'b0;
                    if (!stub) begin
                        cv_done <= 1'b1;
                        cv_bcd  <= to_bcd(cv_bin);
                    end
                end else begin
                    cv_cnt <= cv_cnt - 1;
                end
            end else if (bus.conv_start && bus.conv_ready) begin
                cv_busy   <= 1'b1;
                cv_cnt    <= LAT;
                cv_bin    <= bus.conv_bin;
                start_cnt <= start_cnt + 1;
                st_cyc    <= cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input bit is_err, input logic [BCD_W-1:0] bcd);
        exp_t e;
        e.id = id; e.is_err = is_err; e.bcd = bcd;
        sb.push_back(e);
    endtask

    // Waits for done/err on one line; expiry counts as a failure.
    task automatic wait_pulse(input int id, input bit is_err, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge clk);
            if (is_err ? bus.err[id] : bus.done[id]) seen = 1'b1;
        end
        chk($sformatf("%s_pulse[%0d]_seen", is_err ? "err" : "done", id), 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        chk("sb_empty_before_reset", 32'(sb.size()), 32'd0);
        @(negedge clk);
        bus.req = '0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic monitor();
        exp_t        e;
        logic [N-1:0] ev;
        forever begin
            @(negedge clk);
            if ((bus.done | bus.err) != '0) begin
                chk("done_err_onehot", 32'($onehot(bus.done | bus.err)), 32'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {bus.err, bus.done}, 32'd0);
                end else begin
                    e  = sb.pop_front();
                    ev = '0;
                    ev[e.id] = 1'b1;
                    chk(e.is_err ? "err_vec" : "done_vec", {bus.err, bus.done},
                        e.is_err ? {ev, 4'b0} : {4'b0, ev});
                    chk("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
                end
            end
        end
    endtask

    task automatic run_tests();
        int s0;
        reset = 1'b0;
        bus.req = '0;
        bus.bin_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_bcd_out", 32'(bus.bcd_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_conv_start", 32'(bus.conv_start), 32'd0);
        chk("rst_conv_bin", 32'(bus.conv_bin), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // single request, max operand
        s0 = start_cnt;
        bus.bin_in[1] = 8'd255;
        push(1, 0, 16'h0255);
        bus.req = 4'b0010;
        wait_pulse(1, 0, 200);
        bus.req[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_start_count", 32'(start_cnt - s0), 32'd1);

        // two simultaneous requests
        do_reset();
        s0 = start_cnt;
        bus.bin_in[0] = 8'd42;
        bus.bin_in[2] = 8'd199;
        push(0, 0, 16'h0042);
        push(2, 0, 16'h0199);
        bus.req = 4'b0101;
        wait_pulse(0, 0, 200);
        bus.req[0] = 1'b0;
        wait_pulse(2, 0, 200);
        bus.req[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_start_count", 32'(start_cnt - s0), 32'd2);

        // all requests held: rotation 0,1,2,3,0
        do_reset();
        bus.bin_in = {8'd99, 8'd10, 8'd9, 8'd0};
        push(0, 0, 16'h0000);
        push(1, 0, 16'h0009);
        push(2, 0, 16'h0010);
        push(3, 0, 16'h0099);
        push(0, 0, 16'h0000);
        bus.req = 4'b1111;
        wait_pulse(0, 0, 200);
        wait_pulse(1, 0, 200);
        wait_pulse(2, 0, 200);
        wait_pulse(3, 0, 200);
        wait_pulse(0, 0, 200);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // hung converter: watchdog abort, then next requester served
        do_reset();
        bus.bin_in[3] = 8'd66;
        push(3, 0, 16'h0066);
        bus.req = 4'b1000;
        wait_pulse(3, 0, 200);
        bus.req = '0;
        stub = 1'b1;
        bus.bin_in[0] = 8'd5;
        bus.bin_in[1] = 8'd123;
        push(0, 1, 16'h0066);
        push(1, 0, 16'h0123);
        bus.req = 4'b0011;
        wait_pulse(0, 1, 200);
        // err register is set on the edge just before this sample
        chk("t4_err_latency", 32'(cyc - 1 - st_cyc), 32'd64);
        stub = 1'b0;
        bus.req[0] = 1'b0;
        wait_pulse(1, 0, 200);
        bus.req[1] = 1'b0;
        repeat (3) @(negedge clk);

        // converter not ready for 10 cycles during ISSUE
        do_reset();
        s0 = start_cnt;
        ready_en = 1'b0;
        bus.bin_in[2] = 8'd88;
        push(2, 0, 16'h0088);
        bus.req = 4'b0100;
        @(negedge clk);
        chk("t5_busy_in_issue", 32'(bus.busy), 32'd1);
        bus.bin_in[2] = 8'd11;
        for (int k = 0; k < 10; k++) begin
            chk("t5_no_start", 32'(bus.conv_start), 32'd0);
            chk("t5_conv_bin_stable", 32'(bus.conv_bin), 32'd88);
            @(negedge clk);
        end
        ready_en = 1'b1;
        #1;
        chk("t5_start_when_ready", 32'(bus.conv_start), 32'd1);
        @(negedge clk);
        chk("t5_conv_bin_in_wait", 32'(bus.conv_bin), 32'd88);
        wait_pulse(2, 0, 200);
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("t5_start_count", 32'(start_cnt - s0), 32'd1);

        // reset during WAIT
        do_reset();
        bus.bin_in[1] = 8'd31;
        push(1, 0, 16'h0031);
        bus.req = 4'b0010;
        wait_pulse(1, 0, 200);
        bus.req = '0;
        bus.bin_in[3] = 8'd50;
        bus.req = 4'b1000;
        for (int k = 0; k < 50 && !cv_busy; k++) @(negedge clk);
        chk("t6_conversion_started", 32'(cv_busy), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus.req = '0;
        #1;
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        chk("t6_rst_bcd_out", 32'(bus.bcd_out), 32'd0);
        chk("t6_rst_conv_bin", 32'(bus.conv_bin), 32'd0);
        chk("t6_rst_done_err", {bus.err, bus.done}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.bin_in[1] = 8'd72;
        push(1, 0, 16'h0072);
        push(3, 0, 16'h0050);
        bus.req = 4'b1010;
        wait_pulse(1, 0, 200);
        bus.req[1] = 1'b0;
        wait_pulse(3, 0, 200);
        bus.req[3] = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_empty_at_end", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        fork
            monitor();
            run_tests();
            begin
                #2_000_000;
                n_fail++;
                $display("FAIL global_timeout: got running, expected finished");
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
